generator_arbiter: RTL and testbench

- Shares one generated-generator instance (start/done, two-output tuple stream) between N_REQ requesters.
- Grants in round-robin order and latches the winner's arguments.
- Pulses the generator's start, forwards its output tuples to the winner under valid/ready, and reports completion or timeout.
- Sits between requester logic and a single generator module.

---
 rtl/generator_arbiter_if.sv | 37 +++
 rtl/generator_arbiter.sv | 122 ++++++++++++
 tb/tb_generator_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/generator_arbiter_if.sv
// Bundle of requester-side and generator-side signals around generator_arbiter.
// The arbiter uses the master view; requesters plus the shared generator use the slave view.
interface generator_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32,
  parameter int NARGS = 4
);
  logic [N_REQ-1:0]             req;
  logic [N_REQ*NARGS*WIDTH-1:0] req_args;
  logic [N_REQ-1:0]             grant;
  logic [N_REQ-1:0]             req_done;
  logic                         req_err;
  logic                         _valid;
  logic                         _ready;
  logic signed [WIDTH-1:0]      _out0;
  logic signed [WIDTH-1:0]      _out1;
  logic                         busy;
  logic                         gen_start;
  logic [NARGS*WIDTH-1:0]       gen_args;
  logic                         gen_ready;
  logic                         gen_valid;
  logic                         gen_done;
  logic signed [WIDTH-1:0]      gen_out0;
  logic signed [WIDTH-1:0]      gen_out1;

  modport master (
    input  req, req_args, _ready, gen_valid, gen_done, gen_out0, gen_out1,
    output grant, req_done, req_err, _valid, _out0, _out1, busy,
           gen_start, gen_args, gen_ready
  );

  modport slave (
    output req, req_args, _ready, gen_valid, gen_done, gen_out0, gen_out1,
    input  grant, req_done, req_err, _valid, _out0, _out1, busy,
           gen_start, gen_args, gen_ready
  );
endinterface

// File: rtl/generator_arbiter.sv
// Round-robin arbiter sharing one start/done generator between N_REQ requesters,
// streaming its tuples to the current owner with a watchdog against a stalled stream.
module generator_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int NARGS   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                _clock,
  input  logic                _reset,
  generator_arbiter_if.master bus
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int AW = NARGS * WIDTH;

  typedef enum logic [1:0] {IDLE, LAUNCH, STREAM, RELEASE} state_t;

  state_t          state, state_next;
  logic [N_REQ-1:0] grant_q;
  logic [PW-1:0]   owner_q, rr_ptr, pick_idx, scan_idx;
  logic            pick_found;
  logic [AW-1:0]   args_q;
  logic [AW-1:0]   args_arr [N_REQ];
  logic [CW-1:0]   wdog;
  logic            err_q, handshake, timed_out;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      args_arr[i] = bus.req_args[i*AW +: AW];
    end
  end

  // First active request at or after the pointer, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = PW'((int'(rr_ptr) + k) % N_REQ);
      if (!pick_found && bus.req[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next    = state;
    handshake     = 1'b0;
    timed_out     = 1'b0;
    bus._valid    = 1'b0;
    bus._out0     = '0;
    bus._out1     = '0;
    bus.gen_ready = 1'b0;
    bus.req_done  = '0;
    bus.req_err   = 1'b0;
    case (state)
      IDLE:    if (pick_found) state_next = LAUNCH;
      LAUNCH:  state_next = STREAM;
      STREAM: begin
        bus._valid    = bus.gen_valid;
        bus._out0     = bus.gen_out0;
        bus._out1     = bus.gen_out1;
        bus.gen_ready = bus._ready;
        handshake     = bus.gen_valid && bus._ready;
        // A done with a tuple still pending waits for that tuple to be accepted.
        if (bus.gen_done && !bus.gen_valid) begin
          state_next = RELEASE;
        end else if (!handshake && wdog == CW'(TIMEOUT - 1)) begin
          state_next = RELEASE;
          timed_out  = 1'b1;
        end
      end
      RELEASE: begin
        bus.req_done = grant_q;
        bus.req_err  = err_q;
        state_next   = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      grant_q <= '0;
      owner_q <= '0;
      rr_ptr  <= '0;
      args_q  <= '0;
      wdog    <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_found) begin
          grant_q <= N_REQ'(1) << pick_idx;
          owner_q <= pick_idx;
          args_q  <= args_arr[pick_idx];
        end
        LAUNCH: wdog <= '0;
        STREAM: begin
          wdog  <= handshake ? '0 : wdog + 1'b1;
          err_q <= timed_out;
        end
        RELEASE: begin
          grant_q <= '0;
          rr_ptr  <= (owner_q == PW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.grant     = grant_q;
  assign bus.busy      = (state != IDLE);
  assign bus.gen_start = (state == LAUNCH);
  assign bus.gen_args  = args_q;
endmodule

// File: tb/tb_generator_arbiter.sv
// Bench for generator_arbiter: scenario tasks drive requesters and a scripted generator,
// while negedge monitors compare forwarded tuples and completions against scoreboard queues.
module tb_generator_arbiter;
  localparam int N_REQ   = 4;
  localparam int WIDTH   = 32;
  localparam int NARGS   = 4;
  localparam int TIMEOUT = 8;
  localparam int AW      = NARGS * WIDTH;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  generator_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH), .NARGS(NARGS)) bus ();

  generator_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .NARGS(NARGS), .TIMEOUT(TIMEOUT)) dut (
    ._clock(clock),
    ._reset(reset),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  logic signed [WIDTH-1:0] exp0_q [$];
  logic signed [WIDTH-1:0] exp1_q [$];
  logic [N_REQ-1:0]        done_mask_q [$];
  logic                    done_err_q [$];

  logic signed [WIDTH-1:0] mon_e0, mon_e1;
  logic [N_REQ-1:0]        mon_mask;
  logic                    mon_err;

  // Requester i carries arguments i*16+1 .. i*16+NARGS, argument 0 in the low slot.
  function automatic logic [AW-1:0] args_of(input int i);
    logic [AW-1:0] r;
    r = '0;
    for (int j = 0; j < NARGS; j++) r[j*WIDTH +: WIDTH] = WIDTH'(i*16 + j + 1);
    return r;
  endfunction

  always @(negedge clock) begin
    if (!reset && bus._valid && bus._ready) begin
      checks++;
      if (exp0_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL tuple_unexpected got (%0d,%0d) want none", bus._out0, bus._out1);
      end else begin
        mon_e0 = exp0_q.pop_front();
        mon_e1 = exp1_q.pop_front();
        if (bus._out0 !== mon_e0 || bus._out1 !== mon_e1) begin
          errors++;
          $display("[TB] FAIL tuple got (%0d,%0d) want (%0d,%0d)", bus._out0, bus._out1, mon_e0, mon_e1);
        end
      end
    end
    if (!reset && (|bus.req_done)) begin
      checks++;
      if (done_mask_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL done_unexpected got %b err %b want none", bus.req_done, bus.req_err);
      end else begin
        mon_mask = done_mask_q.pop_front();
        mon_err  = done_err_q.pop_front();
        if (bus.req_done !== mon_mask || bus.req_err !== mon_err) begin
          errors++;
          $display("[TB] FAIL done got %b err %b want %b err %b", bus.req_done, bus.req_err, mon_mask, mon_err);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_launch(input logic [N_REQ-1:0] exp_grant, input int exp_owner, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clock);
      cycles++;
      if (bus.gen_start) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL launch_timeout grant %b want %b", bus.grant, exp_grant);
    end else if (bus.grant !== exp_grant || bus.gen_args !== args_of(exp_owner)) begin
      errors++;
      $display("[TB] FAIL launch grant %b args %h want %b args %h", bus.grant, bus.gen_args, exp_grant, args_of(exp_owner));
    end
  endtask

  // Called at the start of the first STREAM cycle; leaves off at the start of RELEASE.
  task automatic serve(input int ntup, input int base);
    for (int k = 0; k < ntup; k++) begin
      bus.gen_valid = 1'b1;
      bus.gen_out0  = WIDTH'(base + 2*k + 1);
      bus.gen_out1  = WIDTH'(base + 2*k + 2);
      bus._ready    = 1'b1;
      exp0_q.push_back(WIDTH'(base + 2*k + 1));
      exp1_q.push_back(WIDTH'(base + 2*k + 2));
      step();
    end
    bus.gen_valid = 1'b0;
    bus.gen_done  = 1'b1;
    step();
    bus.gen_done  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    @(negedge clock);
    checks++;
    if (bus.grant !== '0 || bus.busy !== 1'b0 || bus.gen_args !== '0) begin
      errors++;
      $display("[TB] FAIL reset_state grant %b busy %b args %h want 0 0 0", bus.grant, bus.busy, bus.gen_args);
    end
    checks++;
    if ({bus.gen_start, bus._valid, bus.gen_ready, bus.req_err, bus.req_done} !== 8'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl start %b valid %b gready %b err %b done %b want all 0",
               bus.gen_start, bus._valid, bus.gen_ready, bus.req_err, bus.req_done);
    end
    step();
    reset = 1'b0;
  endtask

  task automatic test_single();
    int cyc;
    step();
    bus.req = 4'b0001;
    @(negedge clock);
    checks++;
    if (bus.grant !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_early grant %b busy %b want 0000 0", bus.grant, bus.busy);
    end
    done_mask_q.push_back(4'b0001);
    done_err_q.push_back(1'b0);
    wait_launch(4'b0001, 0, cyc);
    checks++;
    if (cyc !== 1 || bus.gen_args !== {32'd4, 32'd3, 32'd2, 32'd1}) begin
      errors++;
      $display("[TB] FAIL single_launch cycles %0d args %h want 1 args 4,3,2,1", cyc, bus.gen_args);
    end
    step();
    bus.req = 4'b0000;
    serve(2, 0);
    @(negedge clock);
    checks++;
    if (bus.gen_start !== 1'b0 || bus.busy !== 1'b1 || bus.grant !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL single_release start %b busy %b grant %b want 0 1 0001", bus.gen_start, bus.busy, bus.grant);
    end
    step();
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0 || bus.grant !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL single_idle busy %b grant %b want 0 0000", bus.busy, bus.grant);
    end
  endtask

  task automatic test_reset_mid_stream();
    int cyc;
    step();
    bus.req = 4'b0100;
    wait_launch(4'b0100, 2, cyc);
    step();
    bus.req       = 4'b0000;
    bus.gen_valid = 1'b1;
    bus.gen_out0  = 55;
    bus.gen_out1  = 56;
    bus._ready    = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.grant !== '0 || bus.gen_start !== 1'b0 || bus.busy !== 1'b0 || bus._valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid grant %b start %b busy %b valid %b want 0 0 0 0",
               bus.grant, bus.gen_start, bus.busy, bus._valid);
    end
    step();
    step();
    bus.gen_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    int cyc;
    step();
    bus.req = 4'b1111;
    for (int i = 0; i < N_REQ; i++) begin
      done_mask_q.push_back(N_REQ'(1) << i);
      done_err_q.push_back(1'b0);
      wait_launch(N_REQ'(1) << i, i, cyc);
      checks++;
      if (cyc !== ((i == 0) ? 2 : 3)) begin
        errors++;
        $display("[TB] FAIL rr_gap owner %0d cycles %0d want %0d", i, cyc, (i == 0) ? 2 : 3);
      end
      step();
      if (i == N_REQ - 1) bus.req = 4'b0001;
      serve(1, 100 * i);
    end
    done_mask_q.push_back(4'b0001);
    done_err_q.push_back(1'b0);
    wait_launch(4'b0001, 0, cyc);
    step();
    bus.req = 4'b0000;
    serve(1, 400);
  endtask

  task automatic test_back_pressure();
    int cyc;
    step();
    bus.req = 4'b0010;
    done_mask_q.push_back(4'b0010);
    done_err_q.push_back(1'b0);
    wait_launch(4'b0010, 1, cyc);
    step();
    bus.req       = 4'b0000;
    bus.gen_valid = 1'b1;
    bus.gen_out0  = -7;
    bus.gen_out1  = 8;
    bus._ready    = 1'b0;
    exp0_q.push_back(-7);
    exp1_q.push_back(8);
    for (int s = 0; s < 5; s++) begin
      @(negedge clock);
      checks++;
      if (bus.gen_ready !== 1'b0 || bus._valid !== 1'b1 || bus._out0 !== -32'sd7) begin
        errors++;
        $display("[TB] FAIL bp_stall cycle %0d gready %b valid %b out0 %0d want 0 1 -7",
                 s, bus.gen_ready, bus._valid, bus._out0);
      end
      step();
    end
    bus._ready = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.gen_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release gready %b want 1", bus.gen_ready);
    end
    step();
    bus.gen_valid = 1'b0;
    bus.gen_done  = 1'b1;
    step();
    bus.gen_done  = 1'b0;
  endtask

  task automatic test_done_with_valid();
    int cyc;
    step();
    bus.req = 4'b0100;
    done_mask_q.push_back(4'b0100);
    done_err_q.push_back(1'b0);
    wait_launch(4'b0100, 2, cyc);
    step();
    bus.req       = 4'b0000;
    bus.gen_valid = 1'b1;
    bus.gen_done  = 1'b1;
    bus.gen_out0  = 21;
    bus.gen_out1  = 22;
    bus._ready    = 1'b0;
    exp0_q.push_back(21);
    exp1_q.push_back(22);
    for (int s = 0; s < 3; s++) begin
      @(negedge clock);
      checks++;
      if (bus.busy !== 1'b1 || bus.req_done !== 4'b0000 || bus._valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL dwv_hold cycle %0d busy %b done %b valid %b want 1 0000 1",
                 s, bus.busy, bus.req_done, bus._valid);
      end
      step();
    end
    bus._ready = 1'b1;
    step();
    bus.gen_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.req_done !== 4'b0000 || bus.busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL dwv_last done %b busy %b want 0000 1", bus.req_done, bus.busy);
    end
    step();
    bus.gen_done = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.req_done !== 4'b0100 || bus.req_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL dwv_done done %b err %b want 0100 0", bus.req_done, bus.req_err);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    int stream_cycles;
    bit got;
    step();
    bus.req = 4'b1001;
    done_mask_q.push_back(4'b1000);
    done_err_q.push_back(1'b1);
    done_mask_q.push_back(4'b0001);
    done_err_q.push_back(1'b0);
    wait_launch(4'b1000, 3, cyc);
    step();
    bus.gen_valid = 1'b0;
    bus.gen_done  = 1'b0;
    bus._ready    = 1'b1;
    stream_cycles = 0;
    got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clock);
      if (bus.req_done !== 4'b0000) got = 1'b1;
      else stream_cycles++;
    end
    checks++;
    if (!got || stream_cycles !== TIMEOUT || bus.req_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout seen %b stream_cycles %0d err %b want 1 %0d 1", got, stream_cycles, bus.req_err, TIMEOUT);
    end
    wait_launch(4'b0001, 0, cyc);
    checks++;
    if (cyc !== 2) begin
      errors++;
      $display("[TB] FAIL timeout_next cycles %0d want 2", cyc);
    end
    step();
    bus.req = 4'b0000;
    serve(1, 600);
    step();
    step();
    @(negedge clock);
    checks++;
    if (exp0_q.size() !== 0 || done_mask_q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL leftover tuples %0d dones %0d want 0 0", exp0_q.size(), done_mask_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout reached");
    $fatal(1, "[TB] bench did not finish");
  end

  initial begin
    reset         = 1'b1;
    bus.req       = '0;
    bus._ready    = 1'b0;
    bus.gen_valid = 1'b0;
    bus.gen_done  = 1'b0;
    bus.gen_out0  = '0;
    bus.gen_out1  = '0;
    for (int i = 0; i < N_REQ; i++) bus.req_args[i*AW +: AW] = args_of(i);
    test_reset();
    test_single();
    test_reset_mid_stream();
    test_round_robin();
    test_back_pressure();
    test_done_with_valid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
